wb_scoreboard_unit: RTL and testbench

//   Write-back stage and register scoreboard for the ARM pipeline. Registers the MEM-stage

---
 rtl/wb_scoreboard_unit_if.sv | 43 ++++
 rtl/wb_scoreboard_unit.sv | 82 ++++++++
 tb/tb_wb_scoreboard_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_scoreboard_unit_if.sv
// Bus bundle for the write-back / scoreboard unit.
// master: the pipeline side (ID and MEM stages) driving requests.
// slave:  the unit itself, producing the register file write port and hazard flags.
interface wb_scoreboard_unit_if #(
    parameter int DATA_W = 32
);
    logic              issue_valid;
    logic              issue_wb_en;
    logic [3:0]        issue_dest;
    logic              mem_valid;
    logic              mem_wb_en;
    logic              mem_is_load;
    logic [3:0]        mem_dest;
    logic [DATA_W-1:0] mem_alu_res;
    logic [DATA_W-1:0] mem_rdata;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              src1_used;
    logic              src2_used;
    logic              writeback_enable;
    logic [3:0]        dest_wb;
    logic [DATA_W-1:0] result_wb;
    logic              hazard;
    logic              issue_stall;
    logic              err_overflow;
    logic              err_underflow;

    modport master (
        output issue_valid, issue_wb_en, issue_dest,
        output mem_valid, mem_wb_en, mem_is_load, mem_dest, mem_alu_res, mem_rdata,
        output src1, src2, src1_used, src2_used,
        input  writeback_enable, dest_wb, result_wb,
        input  hazard, issue_stall, err_overflow, err_underflow
    );

    modport slave (
        input  issue_valid, issue_wb_en, issue_dest,
        input  mem_valid, mem_wb_en, mem_is_load, mem_dest, mem_alu_res, mem_rdata,
        input  src1, src2, src1_used, src2_used,
        output writeback_enable, dest_wb, result_wb,
        output hazard, issue_stall, err_overflow, err_underflow
    );
endinterface

// File: rtl/wb_scoreboard_unit.sv
// Write-back stage plus per-register pending-write scoreboard.
// The WB register drives the register file write port; each register keeps a
// small counter of writes issued but not yet retired, which flags RAW hazards.
module wb_scoreboard_unit #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 16,
    parameter int CNT_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    wb_scoreboard_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [REG_COUNT-1:0][CNT_W-1:0] cnt;
    logic [REG_COUNT-1:0]            inc_vec;
    logic [REG_COUNT-1:0]            dec_vec;
    logic                            issue_req;
    logic                            stall;
    logic                            underflow_now;

    assign issue_req = bus.issue_valid & bus.issue_wb_en;
    assign stall     = issue_req & (cnt[bus.issue_dest] == CNT_MAX);

    assign bus.issue_stall = stall;
    // Counters are read before this cycle's update, so a retiring write still flags.
    assign bus.hazard = (bus.src1_used & (cnt[bus.src1] != '0)) |
                        (bus.src2_used & (cnt[bus.src2] != '0));

    // A retirement that coincides with an issue to the same register nets to zero
    // change and is never an underflow.
    assign underflow_now = bus.writeback_enable & (cnt[bus.dest_wb] == '0) &
                           ~inc_vec[bus.dest_wb];

    // Per-register increment/decrement strobes.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            inc_vec[r] = issue_req & ~stall & (bus.issue_dest == 4'(r));
            dec_vec[r] = bus.writeback_enable & (bus.dest_wb == 4'(r));
        end
    end

    // WB register: data/index follow MEM every cycle, the strobe qualifies the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.writeback_enable <= 1'b0;
            bus.dest_wb          <= '0;
            bus.result_wb        <= '0;
        end else begin
            bus.writeback_enable <= bus.mem_valid & bus.mem_wb_en;
            bus.dest_wb          <= bus.mem_dest;
            bus.result_wb        <= bus.mem_is_load ? bus.mem_rdata : bus.mem_alu_res;
        end
    end

    // Pending-write counters; saturated issues are dropped, empty retirements hold at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err_overflow  <= 1'b0;
            bus.err_underflow <= 1'b0;
        end else begin
            if (stall)         bus.err_overflow  <= 1'b1;
            if (underflow_now) bus.err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_scoreboard_unit.sv
// Bench for wb_scoreboard_unit: directed scenarios plus a randomized run,
// all checked against a pending-count model kept as plain integers.
module tb_wb_scoreboard_unit;
    localparam int DATA_W = 32;
    localparam int MAXC   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_scoreboard_unit_if #(.DATA_W(DATA_W)) bus ();

    wb_scoreboard_unit #(.DATA_W(DATA_W), .REG_COUNT(16), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    int          m_cnt [16];
    bit          m_wbe;
    logic [3:0]  m_dest;
    logic [31:0] m_res;
    bit          m_ovf, m_unf;

    function automatic void model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_wbe = 0; m_dest = 0; m_res = 0; m_ovf = 0; m_unf = 0;
    endfunction

    function automatic bit exp_stall();
        return bus.issue_valid && bus.issue_wb_en && m_cnt[bus.issue_dest] == MAXC;
    endfunction

    function automatic bit exp_hazard();
        return (bus.src1_used && m_cnt[bus.src1] != 0) || (bus.src2_used && m_cnt[bus.src2] != 0);
    endfunction

    task automatic clr_in();
        bus.issue_valid = 0; bus.issue_wb_en = 0; bus.issue_dest = 0;
        bus.mem_valid = 0; bus.mem_wb_en = 0; bus.mem_is_load = 0; bus.mem_dest = 0;
        bus.mem_alu_res = 0; bus.mem_rdata = 0;
        bus.src1 = 0; bus.src2 = 0; bus.src1_used = 0; bus.src2_used = 0;
    endtask

    task automatic issue(input int r);
        bus.issue_valid = 1; bus.issue_wb_en = 1; bus.issue_dest = 4'(r);
    endtask

    task automatic mem(input int r, input bit ld, input logic [31:0] alu, input logic [31:0] rd);
        bus.mem_valid = 1; bus.mem_wb_en = 1; bus.mem_dest = 4'(r);
        bus.mem_is_load = ld; bus.mem_alu_res = alu; bus.mem_rdata = rd;
    endtask

    // Advance one clock, moving the model forward with the inputs currently applied.
    task automatic tick();
        bit inc;
        int ir, dr;
        inc = bus.issue_valid && bus.issue_wb_en && !exp_stall();
        ir  = int'(bus.issue_dest);
        dr  = int'(m_dest);
        if (exp_stall()) m_ovf = 1;
        if (m_wbe && inc && ir == dr) begin
            // net zero
        end else begin
            if (inc) m_cnt[ir]++;
            if (m_wbe) begin
                if (m_cnt[dr] == 0) m_unf = 1;
                else m_cnt[dr]--;
            end
        end
        m_wbe  = bus.mem_valid && bus.mem_wb_en;
        m_dest = bus.mem_dest;
        m_res  = bus.mem_is_load ? bus.mem_rdata : bus.mem_alu_res;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.writeback_enable !== 1'b0) begin n_fail++; $display("FAIL reset_wbe got %b want 0", bus.writeback_enable); end
        n_checks++;
        if (bus.dest_wb !== 4'd0 || bus.result_wb !== 32'd0) begin n_fail++;
            $display("FAIL reset_wb_regs got dest=%0d res=%h want 0/0", bus.dest_wb, bus.result_wb); end
        n_checks++;
        if ({bus.err_overflow, bus.err_underflow} !== 2'b00) begin n_fail++;
            $display("FAIL reset_err got %b%b want 00", bus.err_overflow, bus.err_underflow); end
    endtask

    task automatic test_alu_wb();
        clr_in(); issue(3); tick();
        clr_in(); mem(3, 0, 32'h1234, 32'hFFFF_0000);
        bus.src1 = 3; bus.src1_used = 1; #1;
        n_checks++;
        if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL alu_hazard_pending got %b want 1", bus.hazard); end
        tick();
        bus.mem_valid = 0;
        n_checks++;
        if (bus.writeback_enable !== 1'b1 || bus.dest_wb !== 4'd3 || bus.result_wb !== 32'h1234) begin n_fail++;
            $display("FAIL alu_wb got en=%b dest=%0d res=%h want 1/3/00001234",
                     bus.writeback_enable, bus.dest_wb, bus.result_wb); end
        n_checks++;
        if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL alu_hazard_retiring got %b want 1", bus.hazard); end
        tick();
        n_checks++;
        if (bus.hazard !== 1'b0 || bus.writeback_enable !== 1'b0) begin n_fail++;
            $display("FAIL alu_hazard_clear got hz=%b en=%b want 0/0", bus.hazard, bus.writeback_enable); end
    endtask

    task automatic test_load();
        clr_in(); issue(4); mem(4, 1, 32'h5, 32'hDEADBEEF); tick();
        clr_in();
        n_checks++;
        if (bus.result_wb !== 32'hDEADBEEF || bus.dest_wb !== 4'd4 || bus.writeback_enable !== 1'b1) begin n_fail++;
            $display("FAIL load_wb got en=%b dest=%0d res=%h want 1/4/deadbeef",
                     bus.writeback_enable, bus.dest_wb, bus.result_wb); end
        tick();
    endtask

    task automatic test_overflow();
        clr_in();
        for (int k = 0; k < 3; k++) begin
            issue(5); #1;
            n_checks++;
            if (bus.issue_stall !== 1'b0) begin n_fail++; $display("FAIL ovf_early_stall k=%0d got 1 want 0", k); end
            tick();
        end
        issue(5); bus.src1 = 5; bus.src1_used = 1; #1;
        n_checks++;
        if (bus.issue_stall !== 1'b1) begin n_fail++; $display("FAIL ovf_stall got %b want 1", bus.issue_stall); end
        tick();
        n_checks++;
        if (bus.err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b want 1", bus.err_overflow); end
        n_checks++;
        if (bus.issue_stall !== 1'b1 || bus.hazard !== 1'b1) begin n_fail++;
            $display("FAIL ovf_hold got stall=%b hz=%b want 1/1", bus.issue_stall, bus.hazard); end
        // drain the three pending writes
        clr_in();
        for (int k = 0; k < 3; k++) begin mem(5, 0, 32'(k), 0); tick(); end
        clr_in(); tick();
        bus.src1 = 5; bus.src1_used = 1; #1;
        n_checks++;
        if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL ovf_drained hazard got %b want 0", bus.hazard); end
        clr_in();
    endtask

    task automatic test_same_cycle();
        clr_in(); issue(7); tick();
        clr_in(); mem(7, 0, 32'h77, 0); tick();
        clr_in(); issue(7); bus.src2 = 7; bus.src2_used = 1; tick();
        clr_in(); bus.src2 = 7; bus.src2_used = 1; #1;
        n_checks++;
        if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL same_cycle_hazard got %b want 1", bus.hazard); end
        mem(7, 0, 32'h78, 0); tick();
        bus.mem_valid = 0; tick();
        n_checks++;
        if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL same_cycle_retired got %b want 0", bus.hazard); end
        clr_in();
    endtask

    task automatic test_nowb_underflow();
        clr_in(); bus.mem_valid = 1; bus.mem_wb_en = 0; bus.mem_dest = 2; tick();
        bus.mem_valid = 0; bus.src1 = 2; bus.src1_used = 1; #1;
        n_checks++;
        if (bus.writeback_enable !== 1'b0 || bus.hazard !== 1'b0) begin n_fail++;
            $display("FAIL nowb got en=%b hz=%b want 0/0", bus.writeback_enable, bus.hazard); end
        n_checks++;
        if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL unf_early got 1 want 0"); end
        clr_in(); mem(2, 0, 32'h2, 0); tick();
        clr_in(); tick();
        n_checks++;
        if (bus.err_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_err got %b want 1", bus.err_underflow); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.issue_valid = ($urandom_range(0, 99) < 45); bus.issue_wb_en = ($urandom_range(0, 9) < 8);
            bus.issue_dest  = 4'($urandom_range(0, 7));
            bus.mem_valid   = ($urandom_range(0, 99) < 40); bus.mem_wb_en = ($urandom_range(0, 9) < 8);
            bus.mem_is_load = 1'($urandom); bus.mem_dest = 4'($urandom_range(0, 7));
            bus.mem_alu_res = $urandom; bus.mem_rdata = $urandom;
            bus.src1 = 4'($urandom_range(0, 8)); bus.src2 = 4'($urandom_range(0, 8));
            bus.src1_used = 1'($urandom); bus.src2_used = 1'($urandom);
            #1;
            n_checks++;
            if (bus.hazard !== exp_hazard() || bus.issue_stall !== exp_stall()) begin n_fail++;
                $display("FAIL rnd_comb c=%0d got hz=%b st=%b want %b/%b", c, bus.hazard, bus.issue_stall,
                         exp_hazard(), exp_stall()); end
            tick();
            n_checks++;
            if (bus.writeback_enable !== m_wbe || bus.dest_wb !== m_dest || bus.result_wb !== m_res ||
                bus.err_overflow !== m_ovf || bus.err_underflow !== m_unf) begin n_fail++;
                $display("FAIL rnd_seq c=%0d got en=%b d=%0d r=%h o=%b u=%b want %b/%0d/%h/%b/%b", c,
                         bus.writeback_enable, bus.dest_wb, bus.result_wb, bus.err_overflow, bus.err_underflow,
                         m_wbe, m_dest, m_res, m_ovf, m_unf); end
        end
        clr_in();
    endtask

    task automatic test_async_reset();
        clr_in(); issue(9); tick();
        clr_in(); issue(9); mem(9, 0, 32'h99, 0); tick();
        clr_in(); bus.src1 = 9; bus.src1_used = 1; #3;
        rst = 1; model_reset(); #1;
        n_checks++;
        if (bus.writeback_enable !== 1'b0 || bus.hazard !== 1'b0 || bus.result_wb !== 32'd0) begin n_fail++;
            $display("FAIL async_rst got en=%b hz=%b res=%h want 0/0/0", bus.writeback_enable, bus.hazard, bus.result_wb); end
        n_checks++;
        if ({bus.err_overflow, bus.err_underflow} !== 2'b00) begin n_fail++;
            $display("FAIL async_rst_err got %b%b want 00", bus.err_overflow, bus.err_underflow); end
        #1 rst = 0;
        for (int r = 0; r < 16; r++) begin
            bus.src2 = 4'(r); bus.src2_used = 1; #1;
            n_checks++;
            if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL async_rst_cnt r=%0d got hz=1 want 0", r); end
        end
        clr_in();
    endtask

    initial begin
        clr_in();
        model_reset();
        #12 rst = 0;
        @(posedge clk); #1;
        test_reset();
        test_alu_wb();
        test_load();
        test_overflow();
        test_same_cycle();
        test_nowb_underflow();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
